// File: rtl/wb_gpio_bank.sv
// Wishbone-mapped GPIO bank: per-pad output data and direction, synchronised inputs,
// and rising/falling-edge interrupt status merged onto a single level irq line.
module wb_gpio_bank #(
    parameter int          NUM_PADS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_PADS-1:0] pad_in,
    output logic [NUM_PADS-1:0] pad_out,
    output logic [NUM_PADS-1:0] pad_oeb,
    output logic                irq_o
);

    localparam logic [5:0] OFF_OUT     = 6'h00;
    localparam logic [5:0] OFF_OEB     = 6'h01;
    localparam logic [5:0] OFF_IN      = 6'h02;
    localparam logic [5:0] OFF_RISE_EN = 6'h03;
    localparam logic [5:0] OFF_FALL_EN = 6'h04;
    localparam logic [5:0] OFF_STATUS  = 6'h05;

    logic [NUM_PADS-1:0] out_reg;
    logic [NUM_PADS-1:0] oeb_reg;
    logic [NUM_PADS-1:0] rise_en_reg;
    logic [NUM_PADS-1:0] fall_en_reg;
    logic [NUM_PADS-1:0] status_reg;
    logic [NUM_PADS-1:0] status_next;
    logic [NUM_PADS-1:0] pad_out_reg;
    logic [NUM_PADS-1:0] pad_oeb_reg;
    logic [NUM_PADS-1:0] sync1_reg;
    logic [NUM_PADS-1:0] sync2_reg;
    logic [NUM_PADS-1:0] prev_reg;
    logic [NUM_PADS-1:0] rise;
    logic [NUM_PADS-1:0] fall;
    logic [NUM_PADS-1:0] w1c;
    logic [NUM_PADS-1:0] wr_mask;
    logic [NUM_PADS-1:0] wr_data;

    logic                ack_reg;
    logic [31:0]         dat_reg;
    logic                hit;
    logic                req;
    logic                wr_req;
    logic [5:0]          offset;
    logic [31:0]         lane_mask;
    logic [31:0]         rd_word;
    logic                unused_bits;

    genvar gi;

    // Bus decode: a request is only taken while no ack is outstanding, so a held
    // strobe produces one ack every second cycle.
    assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req    = wbs_cyc_i & wbs_stb_i & hit & ~ack_reg;
    assign wr_req = req & wbs_we_i;
    assign offset = wbs_adr_i[7:2];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{wbs_sel_i[gi]}};
        end
    endgenerate

    assign wr_mask = lane_mask[NUM_PADS-1:0];
    assign wr_data = wbs_dat_i[NUM_PADS-1:0];

    // Address LSBs and data/lane bits above the bank width carry no meaning here.
    assign unused_bits = ^{wbs_adr_i[1:0], lane_mask, wbs_dat_i};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            out_reg     <= '0;
            oeb_reg     <= '1;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
        end else if (wr_req) begin
            case (offset)
                OFF_OUT:     out_reg     <= (out_reg     & ~wr_mask) | (wr_data & wr_mask);
                OFF_OEB:     oeb_reg     <= (oeb_reg     & ~wr_mask) | (wr_data & wr_mask);
                OFF_RISE_EN: rise_en_reg <= (rise_en_reg & ~wr_mask) | (wr_data & wr_mask);
                OFF_FALL_EN: fall_en_reg <= (fall_en_reg & ~wr_mask) | (wr_data & wr_mask);
                default:     ;
            endcase
        end
    end

    // Pads follow the control registers one edge later, all bits from flops.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            pad_out_reg <= '0;
            pad_oeb_reg <= '1;
        end else begin
            pad_out_reg <= out_reg;
            pad_oeb_reg <= oeb_reg;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= pad_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    // New edges are OR-ed in after the write-one-to-clear, so an edge landing on
    // the same cycle as its clear is kept.
    generate
        for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            assign rise[gi]        = sync2_reg[gi] & ~prev_reg[gi];
            assign fall[gi]        = ~sync2_reg[gi] & prev_reg[gi];
            assign w1c[gi]         = wr_req & (offset == OFF_STATUS) & wr_mask[gi] & wr_data[gi];
            assign status_next[gi] = (status_reg[gi] & ~w1c[gi])
                                   | (rise[gi] & rise_en_reg[gi])
                                   | (fall[gi] & fall_en_reg[gi]);
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            status_reg <= '0;
        end else begin
            status_reg <= status_next;
        end
    end

    always_comb begin
        rd_word = '0;
        case (offset)
            OFF_OUT:     rd_word[NUM_PADS-1:0] = out_reg;
            OFF_OEB:     rd_word[NUM_PADS-1:0] = oeb_reg;
            OFF_IN:      rd_word[NUM_PADS-1:0] = sync2_reg;
            OFF_RISE_EN: rd_word[NUM_PADS-1:0] = rise_en_reg;
            OFF_FALL_EN: rd_word[NUM_PADS-1:0] = fall_en_reg;
            OFF_STATUS:  rd_word[NUM_PADS-1:0] = status_reg;
            default:     rd_word = '0;
        endcase
    end

    // Read data is captured with the request and held only for the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_reg <= 1'b0;
            dat_reg <= '0;
        end else begin
            ack_reg <= req;
            dat_reg <= (req && !wbs_we_i) ? rd_word : '0;
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign pad_out   = pad_out_reg;
    assign pad_oeb   = pad_oeb_reg;
    assign irq_o     = |status_reg;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Randomised bench for wb_gpio_bank: a 16-pad and an 8-pad instance share the bus,
// checked against a register/edge model derived from the register map rules.
module tb_wb_gpio_bank;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, we, stb16, stb8;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack16, ack8, irq16, irq8;
    logic [31:0] dat16, dat8;
    logic [15:0] pin16, pout16, poeb16;
    logic [7:0]  pin8, pout8, poeb8;

    int checks = 0;
    int errors = 0;

    // Model registers indexed by word offset: 0 OUT, 1 OEB, 3 RISE_EN, 4 FALL_EN, 5 STATUS.
    logic [15:0] mreg [0:5];

    always #5 clk = ~clk;

    wb_gpio_bank #(.NUM_PADS(16), .BASE_ADDR(BASE)) u_dut16 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb16),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack16), .wbs_dat_o(dat16), .pad_in(pin16), .pad_out(pout16),
        .pad_oeb(poeb16), .irq_o(irq16)
    );

    wb_gpio_bank #(.NUM_PADS(8), .BASE_ADDR(BASE)) u_dut8 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb8),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack8), .wbs_dat_o(dat8), .pad_in(pin8), .pad_out(pout8),
        .pad_oeb(poeb8), .irq_o(irq8)
    );

    function automatic logic [31:0] lanes(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    // One Wishbone transfer; returns at the negedge where ack is seen.
    task automatic bus(input bit d8, input bit w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
        int lat;
        bit got;
        @(negedge clk);
        cyc = 1'b1; we = w; sel = s; adr = a; wdat = d;
        if (d8) stb8 = 1'b1; else stb16 = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            got = d8 ? ack8 : ack16;
        end
        rd = d8 ? dat8 : dat16;
        cyc = 1'b0; stb16 = 1'b0; stb8 = 1'b0; we = 1'b0;
        checks++;
        if (!got || lat != 1) begin
            errors++;
            $display("FAIL bus_ack adr=%h ack_seen=%0b latency=%0d required latency=1", a, got, lat);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (poeb16 !== 16'hFFFF || pout16 !== 16'h0 || irq16 !== 1'b0 || ack16 !== 1'b0 || dat16 !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs oeb=%h out=%h irq=%b ack=%b dat=%h required FFFF 0000 0 0 0",
                     poeb16, pout16, irq16, ack16, dat16);
        end
        bus(0, 0, 4'hF, BASE + 32'h04, 0, rd);
        checks++;
        if (rd !== 32'h0000_FFFF) begin
            errors++; $display("FAIL reset_oeb_read got %h required 0000FFFF", rd);
        end
        bus(0, 0, 4'hF, BASE + 32'h14, 0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_status_read got %h required 0", rd);
        end
        mreg[0] = 16'h0; mreg[1] = 16'hFFFF; mreg[3] = 16'h0; mreg[4] = 16'h0; mreg[5] = 16'h0;
    endtask

    task automatic test_out_byte_lane();
        logic [31:0] rd;
        bus(0, 1, 4'b0001, BASE + 32'h00, 32'h0000_A5C3, rd);
        mreg[0] = 16'h00C3;
        @(negedge clk);
        checks++;
        if (pout16 !== 16'h00C3) begin
            errors++; $display("FAIL byte_lane_pad_out got %h required 00C3", pout16);
        end
        bus(0, 0, 4'hF, BASE + 32'h00, 0, rd);
        checks++;
        if (rd !== 32'h0000_00C3) begin
            errors++; $display("FAIL byte_lane_readback got %h required 000000C3", rd);
        end
        @(negedge clk);
        checks++;
        if (ack16 !== 1'b0 || dat16 !== 32'h0) begin
            errors++; $display("FAIL ack_single_cycle ack=%b dat=%h required 0 0", ack16, dat16);
        end
    endtask

    task automatic test_rise_irq();
        logic [31:0] rd;
        bus(0, 1, 4'hF, BASE + 32'h0C, 32'h1, rd);
        bus(0, 1, 4'hF, BASE + 32'h10, 32'h0, rd);
        mreg[3] = 16'h1; mreg[4] = 16'h0;
        @(negedge clk);
        pin16[0] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (irq16 !== 1'b0) begin
            errors++; $display("FAIL rise_irq_early irq=%b after 2 edges required 0", irq16);
        end
        @(negedge clk);
        checks++;
        if (irq16 !== 1'b1) begin
            errors++; $display("FAIL rise_irq_third_edge irq=%b required 1", irq16);
        end
        bus(0, 0, 4'hF, BASE + 32'h14, 0, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++; $display("FAIL rise_status got %h required 1", rd);
        end
        bus(0, 1, 4'hF, BASE + 32'h14, 32'h1, rd);
        checks++;
        if (irq16 !== 1'b0) begin
            errors++; $display("FAIL w1c_irq_clear irq=%b required 0", irq16);
        end
        pin16[0] = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (irq16 !== 1'b0) begin
            errors++; $display("FAIL fall_disabled irq=%b required 0", irq16);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        bus(0, 1, 4'hF, BASE + 32'h0C, 32'h4, rd);
        bus(0, 1, 4'hF, BASE + 32'h10, 32'h4, rd);
        mreg[3] = 16'h4; mreg[4] = 16'h4;
        @(negedge clk);
        pin16[2] = 1'b1;
        repeat (4) @(negedge clk);
        bus(0, 0, 4'hF, BASE + 32'h14, 0, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++; $display("FAIL collision_setup status got %h required 4", rd);
        end
        // Falling edge reaches STATUS on the third edge, which is also the W1C commit edge.
        @(negedge clk);
        pin16[2] = 1'b0;
        repeat (2) @(negedge clk);
        cyc = 1'b1; stb16 = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h14; wdat = 32'h4;
        @(negedge clk);
        checks++;
        if (ack16 !== 1'b1) begin
            errors++; $display("FAIL collision_ack ack=%b required 1", ack16);
        end
        cyc = 1'b0; stb16 = 1'b0; we = 1'b0;
        bus(0, 0, 4'hF, BASE + 32'h14, 0, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++; $display("FAIL collision_set_wins status got %h required 4", rd);
        end
        bus(0, 1, 4'hF, BASE + 32'h14, 32'h4, rd);
        bus(0, 0, 4'hF, BASE + 32'h14, 0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL collision_clear status got %h required 0", rd);
        end
        mreg[5] = 16'h0;
    endtask

    task automatic test_addr_decode();
        logic [31:0] rd;
        bit bad = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb16 = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack16 !== 1'b0 || dat16 !== 32'h0) bad = 1'b1;
        end
        cyc = 1'b0; stb16 = 1'b0;
        checks++;
        if (bad) begin
            errors++; $display("FAIL addr_miss ack or data seen on miss (ack=%b dat=%h) required none", ack16, dat16);
        end
        bus(0, 0, 4'hF, BASE + 32'h20, 0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL unmapped_read got %h required 0", rd);
        end
        bus(0, 1, 4'hF, BASE + 32'h20, 32'hFFFF_FFFF, rd);
        bus(0, 0, 4'hF, BASE + 32'h00, 0, rd);
        checks++;
        if (rd !== {16'h0, mreg[0]}) begin
            errors++; $display("FAIL unmapped_write_no_effect OUT got %h required %h", rd, mreg[0]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cyc = 1'b1; stb16 = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h0C;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ack16 !== ((i % 2) == 0) || dat16 !== (((i % 2) == 0) ? {16'h0, mreg[3]} : 32'h0)) begin
                errors++;
                $display("FAIL back_to_back cycle %0d ack=%b dat=%h required ack=%0d dat=%h", i, ack16, dat16,
                         (i % 2) == 0, ((i % 2) == 0) ? {16'h0, mreg[3]} : 32'h0);
            end
        end
        cyc = 1'b0; stb16 = 1'b0;
    endtask

    task automatic test_rand_regs();
        logic [31:0] rd, wd, m;
        logic [3:0]  s;
        int          idx;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: idx = 0;
                1: idx = 1;
                2: idx = 3;
                default: idx = 4;
            endcase
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            bus(0, 1, s, BASE + 32'(idx * 4), wd, rd);
            m = lanes(s);
            mreg[idx] = (mreg[idx] & ~m[15:0]) | (wd[15:0] & m[15:0]);
            @(negedge clk);
            checks++;
            if (pout16 !== mreg[0] || poeb16 !== mreg[1]) begin
                errors++;
                $display("FAIL rand_pads iter %0d out=%h oeb=%h required %h %h", n, pout16, poeb16, mreg[0], mreg[1]);
            end
            bus(0, 0, 4'hF, BASE + 32'(idx * 4), 0, rd);
            checks++;
            if (rd !== {16'h0, mreg[idx]}) begin
                errors++;
                $display("FAIL rand_reg iter %0d off=%0d got %h required %h", n, idx * 4, rd, mreg[idx]);
            end
        end
    endtask

    task automatic test_rand_edges();
        logic [31:0] rd, wd, m;
        logic [15:0] old_pad;
        logic [3:0]  s;
        bus(0, 1, 4'hF, BASE + 32'h14, 32'hFFFF_FFFF, rd);
        mreg[5] = 16'h0;
        for (int n = 0; n < 16; n++) begin
            if ((n % 4) == 0) begin
                mreg[3] = 16'($urandom);
                mreg[4] = 16'($urandom);
                bus(0, 1, 4'hF, BASE + 32'h0C, {16'h0, mreg[3]}, rd);
                bus(0, 1, 4'hF, BASE + 32'h10, {16'h0, mreg[4]}, rd);
            end
            old_pad = pin16;
            @(negedge clk);
            pin16 = 16'($urandom);
            repeat (4) @(negedge clk);
            mreg[5] = mreg[5] | (pin16 & ~old_pad & mreg[3]) | (~pin16 & old_pad & mreg[4]);
            checks++;
            if (irq16 !== (mreg[5] != 16'h0)) begin
                errors++; $display("FAIL rand_irq iter %0d irq=%b required %0d", n, irq16, mreg[5] != 16'h0);
            end
            bus(0, 0, 4'hF, BASE + 32'h14, 0, rd);
            checks++;
            if (rd !== {16'h0, mreg[5]}) begin
                errors++; $display("FAIL rand_status iter %0d got %h required %h", n, rd, mreg[5]);
            end
            bus(0, 0, 4'hF, BASE + 32'h08, 0, rd);
            checks++;
            if (rd !== {16'h0, pin16}) begin
                errors++; $display("FAIL rand_in iter %0d got %h required %h", n, rd, pin16);
            end
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            bus(0, 1, s, BASE + 32'h14, wd, rd);
            m = lanes(s) & wd;
            mreg[5] = mreg[5] & ~m[15:0];
            bus(0, 0, 4'hF, BASE + 32'h14, 0, rd);
            checks++;
            if (rd !== {16'h0, mreg[5]}) begin
                errors++; $display("FAIL rand_w1c iter %0d got %h required %h", n, rd, mreg[5]);
            end
        end
    endtask

    task automatic test_narrow_bank();
        logic [31:0] rd;
        bit bad = 1'b0;
        bus(1, 1, 4'hF, BASE + 32'h00, 32'hFFFF_FFFF, rd);
        bus(1, 0, 4'hF, BASE + 32'h00, 0, rd);
        checks++;
        if (rd !== 32'h0000_00FF) begin
            errors++; $display("FAIL narrow_out_read got %h required 000000FF", rd);
        end
        checks++;
        if (pout8 !== 8'hFF) begin
            errors++; $display("FAIL narrow_pad_out got %h required FF", pout8);
        end
        bus(1, 1, 4'hF, BASE + 32'h04, 32'h0, rd);
        bus(1, 1, 4'hF, BASE + 32'h0C, 32'hFFFF_FFFF, rd);
        @(negedge clk);
        cyc = 1'b1; stb8 = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h04; wdat = 32'h55;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack8 !== 1'b0) bad = 1'b1;
        end
        cyc = 1'b0; stb8 = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (bad) begin
            errors++; $display("FAIL reset_pending_ack ack seen during reset required none");
        end
        checks++;
        if (pout8 !== 8'h00 || poeb8 !== 8'hFF || irq8 !== 1'b0 || poeb16 !== 16'hFFFF) begin
            errors++;
            $display("FAIL narrow_reset_pads out=%h oeb=%h irq=%b oeb16=%h required 00 FF 0 FFFF", pout8, poeb8, irq8, poeb16);
        end
        bus(1, 0, 4'hF, BASE + 32'h04, 0, rd);
        checks++;
        if (rd !== 32'h0000_00FF) begin
            errors++; $display("FAIL narrow_reset_oeb got %h required 000000FF", rd);
        end
        bus(1, 0, 4'hF, BASE + 32'h0C, 0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL narrow_reset_rise_en got %h required 0", rd);
        end
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb16 = 1'b0; stb8 = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0; pin16 = 16'h0; pin8 = 8'h0;
        test_reset();
        test_out_byte_lane();
        test_rise_irq();
        test_w1c_collision();
        test_addr_decode();
        test_back_to_back();
        test_rand_regs();
        test_rand_edges();
        test_narrow_bank();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
